// File: rtl/dma_rd_tag_scheduler.sv
// dma_rd_tag_scheduler
//   Turns host-to-card DMA read jobs into PCIe memory-read requests. Each job
//   is split into requests no larger than the max read request size that never
//   cross a 4 KB page. Every request takes the lowest free tag from a window of
//   C_WINDOW_SIZE tags. The per-tag busy flag and expected DW count are exported
//   to the completion logic. That logic releases tags through COMPLETED_TAGS.
//   JOB_DONE pulses once the last request has gone out and every tag is free.
//
// Ports
//   CLK, RST                 clock, asynchronous active-high reset
//   JOB_VALID/READY/ADDR/BYTES  job offer (address and length DW aligned)
//   REQ_VALID/READY/ADDR/DWORDS/TAG  read request to the RQ TLP builder
//   COMPLETED_TAGS           one-cycle per-tag release pulses
//   CURRENT_WINDOW_SIZE      runtime cap on outstanding tags (0 = full window)
//   BUSY_TAGS, SIZE_TAGS     per-tag outstanding flag / expected DW (11 b each)
//   WORD_COUNT               DW issued in the current job
//   JOB_DONE                 one-cycle end-of-job pulse
//   ERROR                    sticky: release pulse seen for a tag that was not busy
module dma_rd_tag_scheduler #(
    parameter int C_WINDOW_SIZE           = 16,
    parameter int C_LOG2_MAX_READ_REQUEST = 9
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        JOB_VALID,
    output logic                        JOB_READY,
    input  logic [63:0]                 JOB_ADDR,
    input  logic [31:0]                 JOB_BYTES,
    output logic                        REQ_VALID,
    input  logic                        REQ_READY,
    output logic [63:0]                 REQ_ADDR,
    output logic [10:0]                 REQ_DWORDS,
    output logic [7:0]                  REQ_TAG,
    input  logic [C_WINDOW_SIZE-1:0]    COMPLETED_TAGS,
    input  logic [63:0]                 CURRENT_WINDOW_SIZE,
    output logic [C_WINDOW_SIZE-1:0]    BUSY_TAGS,
    output logic [C_WINDOW_SIZE*11-1:0] SIZE_TAGS,
    output logic [63:0]                 WORD_COUNT,
    output logic                        JOB_DONE,
    output logic                        ERROR
);

    localparam int          CW     = $clog2(C_WINDOW_SIZE + 1);
    localparam logic [10:0] MAX_DW = 11'(1 << (C_LOG2_MAX_READ_REQUEST - 2));

    typedef enum logic [2:0] {S_IDLE, S_ALLOC, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t              state_reg, state_next;
    logic [63:0]         addr_reg;
    logic [29:0]         rem_reg;
    logic [63:0]         req_addr_reg;
    logic [10:0]         req_dwords_reg;
    logic [7:0]          req_tag_reg;
    logic [63:0]         word_count_reg;
    logic                error_reg;
    logic                busy_arr [C_WINDOW_SIZE];
    logic [10:0]         size_arr [C_WINDOW_SIZE];
    logic [C_WINDOW_SIZE-1:0] busy_vec;

    logic [CW-1:0]       w_eff;
    logic [CW-1:0]       busy_cnt;
    logic [7:0]          free_tag;
    logic                free_any;
    logic                alloc_ok;
    logic [12:0]         to_page;
    logic [10:0]         page_dw;
    logic [10:0]         rem_dw;
    logic [10:0]         chunk_dw;
    logic                job_fire;
    logic                req_fire;

    // Effective window: 0 or anything above the physical window means "all tags".
    always_comb begin
        w_eff = CW'(C_WINDOW_SIZE);
        if (CURRENT_WINDOW_SIZE != 64'd0 && CURRENT_WINDOW_SIZE <= 64'(C_WINDOW_SIZE))
            w_eff = CURRENT_WINDOW_SIZE[CW-1:0];
    end

    // Outstanding count and lowest free tag, both from the registered busy flags.
    always_comb begin
        busy_cnt = '0;
        free_tag = 8'd0;
        free_any = 1'b0;
        for (int i = C_WINDOW_SIZE - 1; i >= 0; i--) begin
            busy_cnt = busy_cnt + CW'(busy_vec[i]);
            if (!busy_vec[i]) begin
                free_tag = 8'(i);
                free_any = 1'b1;
            end
        end
    end

    assign alloc_ok = free_any && (busy_cnt < w_eff);

    // Request length: min(remaining, max read request, DW left in the 4 KB page).
    assign to_page  = 13'd4096 - {1'b0, addr_reg[11:0]};
    assign page_dw  = to_page[12:2];
    assign rem_dw   = (rem_reg > {19'd0, MAX_DW}) ? MAX_DW : rem_reg[10:0];
    assign chunk_dw = (rem_dw < page_dw) ? rem_dw : page_dw;

    assign job_fire = (state_reg == S_IDLE) && JOB_VALID;
    assign req_fire = (state_reg == S_ISSUE) && REQ_READY;

    // FSM: state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (JOB_VALID) state_next = (JOB_BYTES[31:2] == 30'd0) ? S_DONE : S_ALLOC;
            S_ALLOC: if (alloc_ok) state_next = S_ISSUE;
            S_ISSUE: if (REQ_READY)
                         state_next = (rem_reg == {19'd0, req_dwords_reg}) ? S_DRAIN : S_ALLOC;
            S_DRAIN: if (busy_vec == '0) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM: state-decoded outputs
    always_comb begin
        JOB_READY = 1'b0;
        REQ_VALID = 1'b0;
        JOB_DONE  = 1'b0;
        case (state_reg)
            S_IDLE:  JOB_READY = 1'b1;
            S_ISSUE: REQ_VALID = 1'b1;
            S_DONE:  JOB_DONE  = 1'b1;
            default: ;
        endcase
    end

    // Job cursor, request registers and word counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_reg       <= '0;
            rem_reg        <= '0;
            req_addr_reg   <= '0;
            req_dwords_reg <= '0;
            req_tag_reg    <= '0;
            word_count_reg <= '0;
        end else begin
            if (job_fire) begin
                addr_reg       <= {JOB_ADDR[63:2], 2'b00};
                rem_reg        <= JOB_BYTES[31:2];
                word_count_reg <= '0;
            end
            if (state_reg == S_ALLOC && alloc_ok) begin
                req_addr_reg   <= addr_reg;
                req_dwords_reg <= chunk_dw;
                req_tag_reg    <= free_tag;
            end
            if (req_fire) begin
                addr_reg       <= addr_reg + {51'd0, req_dwords_reg, 2'b00};
                rem_reg        <= rem_reg - {19'd0, req_dwords_reg};
                word_count_reg <= word_count_reg + {53'd0, req_dwords_reg};
            end
        end
    end

    // Per-tag bookkeeping. A tag being allocated is never busy, so it cannot
    // also be released in the same cycle; the size is kept after release.
    genvar gi;
    generate
        for (gi = 0; gi < C_WINDOW_SIZE; gi++) begin : g_tag
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    busy_arr[gi] <= 1'b0;
                    size_arr[gi] <= '0;
                end else if (req_fire && req_tag_reg == 8'(gi)) begin
                    busy_arr[gi] <= 1'b1;
                    size_arr[gi] <= req_dwords_reg;
                end else if (COMPLETED_TAGS[gi]) begin
                    busy_arr[gi] <= 1'b0;
                end
            end
            assign busy_vec[gi]           = busy_arr[gi];
            assign SIZE_TAGS[11*gi +: 11] = size_arr[gi];
        end
    endgenerate

    // A release for a tag that is not outstanding is a protocol error.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                                 error_reg <= 1'b0;
        else if (|(COMPLETED_TAGS & ~busy_vec))  error_reg <= 1'b1;
    end

    assign BUSY_TAGS  = busy_vec;
    assign REQ_ADDR   = req_addr_reg;
    assign REQ_DWORDS = req_dwords_reg;
    assign REQ_TAG    = req_tag_reg;
    assign WORD_COUNT = word_count_reg;
    assign ERROR      = error_reg;

endmodule

// File: tb/tb_dma_rd_tag_scheduler.sv
// Testbench for dma_rd_tag_scheduler: directed scenarios followed by random
// jobs. Expected requests are computed from the page/max-size splitting rule
// and queued; a negedge monitor drives REQ_READY / COMPLETED_TAGS and compares
// every handshake and the per-tag bookkeeping against a tag-set model.
module tb_dma_rd_tag_scheduler;
    localparam int NT    = 16;
    localparam int LG    = 9;
    localparam int MAXDW = 1 << (LG - 2);

    logic                CLK = 1'b0;
    logic                RST;
    logic                JOB_VALID;
    logic                JOB_READY;
    logic [63:0]         JOB_ADDR;
    logic [31:0]         JOB_BYTES;
    logic                REQ_VALID;
    logic                REQ_READY;
    logic [63:0]         REQ_ADDR;
    logic [10:0]         REQ_DWORDS;
    logic [7:0]          REQ_TAG;
    logic [NT-1:0]       COMPLETED_TAGS;
    logic [63:0]         CURRENT_WINDOW_SIZE;
    logic [NT-1:0]       BUSY_TAGS;
    logic [NT*11-1:0]    SIZE_TAGS;
    logic [63:0]         WORD_COUNT;
    logic                JOB_DONE;
    logic                ERROR;

    dma_rd_tag_scheduler #(.C_WINDOW_SIZE(NT), .C_LOG2_MAX_READ_REQUEST(LG)) dut (
        .CLK(CLK), .RST(RST),
        .JOB_VALID(JOB_VALID), .JOB_READY(JOB_READY), .JOB_ADDR(JOB_ADDR), .JOB_BYTES(JOB_BYTES),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR),
        .REQ_DWORDS(REQ_DWORDS), .REQ_TAG(REQ_TAG),
        .COMPLETED_TAGS(COMPLETED_TAGS), .CURRENT_WINDOW_SIZE(CURRENT_WINDOW_SIZE),
        .BUSY_TAGS(BUSY_TAGS), .SIZE_TAGS(SIZE_TAGS), .WORD_COUNT(WORD_COUNT),
        .JOB_DONE(JOB_DONE), .ERROR(ERROR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0] addr;
        int          dw;
        int          tag;   // -1: any free tag is acceptable
    } req_t;

    req_t          exp_q[$];
    logic [63:0]   done_q[$];
    int            checks = 0;
    int            errors = 0;
    bit            model_busy [NT];
    int            model_size [NT];
    bit            model_err;
    logic [63:0]   model_wc;
    int            model_cnt;
    int            ready_mode;      // 0 random, 1 high, 2 low
    int            comp_mode;       // 0 none (forced only), 1 random
    logic [NT-1:0] comp_force_val;
    bit            comp_force_req;

    function automatic void chk(string nm, logic [255:0] act, logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endfunction

    function automatic int eff_w(logic [63:0] c);
        if (c == 64'd0 || c > 64'(NT)) return NT;
        return int'(c);
    endfunction

    // Monitor / responder: compare state of the previous edge, choose the
    // inputs for the next edge, then advance the model by what that edge does.
    always @(negedge CLK) begin
        logic [NT-1:0]    comp;
        logic [NT-1:0]    eb;
        logic [NT*11-1:0] esz;
        bit               rdy;
        req_t             e;
        logic [63:0]      w;
        int               t;
        if (RST) begin
            REQ_READY      = 1'b0;
            COMPLETED_TAGS = '0;
            for (int j = 0; j < NT; j++) begin
                model_busy[j] = 1'b0;
                model_size[j] = 0;
            end
            model_err = 1'b0;
            model_wc  = '0;
            model_cnt = 0;
            exp_q.delete();
            done_q.delete();
        end else begin
            for (int j = 0; j < NT; j++) begin
                eb[j]         = model_busy[j];
                esz[11*j +: 11] = 11'(model_size[j]);
            end
            chk("busy_tags", 256'(BUSY_TAGS), 256'(eb));
            chk("size_tags", 256'(SIZE_TAGS), 256'(esz));
            chk("error", 256'(ERROR), 256'(model_err));
            chk("word_count", 256'(WORD_COUNT), 256'(model_wc));
            if (JOB_DONE) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_job_done", 256'(JOB_DONE), 256'(0));
                end else begin
                    w = done_q.pop_front();
                    chk("done_words", 256'(WORD_COUNT), 256'(w));
                    chk("done_requests_left", 256'(exp_q.size()), 256'(0));
                end
            end

            case (ready_mode)
                0:       rdy = ($urandom_range(0, 9) < 7);
                1:       rdy = 1'b1;
                default: rdy = 1'b0;
            endcase
            comp = '0;
            if (comp_force_req) begin
                comp           = comp_force_val;
                comp_force_req = 1'b0;
            end else if (comp_mode == 1) begin
                for (int j = 0; j < NT; j++)
                    if (model_busy[j] && $urandom_range(0, 3) == 0) comp[j] = 1'b1;
            end
            REQ_READY      = rdy;
            COMPLETED_TAGS = comp;

            if (JOB_VALID && JOB_READY) model_wc = '0;

            t = -1;
            if (REQ_VALID && rdy) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_request", 256'(REQ_VALID), 256'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("req_addr", 256'(REQ_ADDR), 256'(e.addr));
                    chk("req_dwords", 256'(REQ_DWORDS), 256'(e.dw));
                    chk("req_within_window", 256'(model_cnt < eff_w(CURRENT_WINDOW_SIZE)), 256'(1));
                    if (e.tag >= 0) begin
                        chk("req_tag", 256'(REQ_TAG), 256'(e.tag));
                        t = e.tag;
                    end else begin
                        chk("req_tag_range", 256'(int'(REQ_TAG) < NT), 256'(1));
                        if (int'(REQ_TAG) < NT) begin
                            chk("req_tag_free", 256'(model_busy[REQ_TAG]), 256'(0));
                            t = int'(REQ_TAG);
                        end
                    end
                    model_wc = model_wc + 64'(e.dw);
                end
            end
            for (int j = 0; j < NT; j++) begin
                if (comp[j]) begin
                    if (model_busy[j]) model_busy[j] = 1'b0;
                    else               model_err     = 1'b1;
                end
            end
            if (t >= 0) begin
                model_busy[t] = 1'b1;
                model_size[t] = e.dw;
            end
            model_cnt = 0;
            for (int j = 0; j < NT; j++) model_cnt += int'(model_busy[j]);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    // Expected split: each request stops at the max read request size or the
    // next 4 KB page, whichever comes first. k>0 expects tags i%k.
    task automatic submit(logic [63:0] addr, logic [31:0] bytes, int k);
        logic [63:0] a;
        longint      rem;
        longint      page;
        longint      n;
        logic [63:0] total;
        int          i;
        bit          ok;
        req_t        r;
        a     = addr & ~64'd3;
        rem   = longint'(bytes) / 4;
        total = '0;
        i     = 0;
        while (rem > 0) begin
            page = longint'((64'd4096 - (a % 64'd4096)) / 64'd4);
            n = rem;
            if (n > MAXDW) n = MAXDW;
            if (n > page)  n = page;
            r.addr = a;
            r.dw   = int'(n);
            r.tag  = (k > 0) ? (i % k) : -1;
            exp_q.push_back(r);
            a     = a + 64'(n * 4);
            rem   = rem - n;
            total = total + 64'(n);
            i++;
        end
        done_q.push_back(total);
        $display("job addr=%h bytes=%0d requests=%0d words=%0d", addr, bytes, i, total);
        @(posedge CLK);
        #1;
        JOB_ADDR  = addr;
        JOB_BYTES = bytes;
        JOB_VALID = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            if (JOB_READY) begin
                ok = 1'b1;
                break;
            end
        end
        chk("job_accept_timeout", 256'(ok), 256'(1));
        @(posedge CLK);
        #1;
        JOB_VALID = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            tick();
            if (done_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("job_done_timeout", 256'(ok), 256'(1));
    endtask

    task automatic wait_cnt(int n);
        bit ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (model_cnt == n) begin
                ok = 1'b1;
                break;
            end
        end
        chk("outstanding_timeout", 256'(ok), 256'(1));
    endtask

    task automatic force_comp(logic [NT-1:0] v);
        comp_force_val = v;
        comp_force_req = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] a0;
        logic [10:0] d0;
        logic [7:0]  t0;
        bit          ok;
        RST = 1'b1;
        JOB_VALID = 1'b0;
        JOB_ADDR = '0;
        JOB_BYTES = '0;
        REQ_READY = 1'b0;
        COMPLETED_TAGS = '0;
        CURRENT_WINDOW_SIZE = '0;
        ready_mode = 1;
        comp_mode = 0;
        comp_force_req = 1'b0;
        comp_force_val = '0;
        repeat (3) tick();
        chk("reset_job_ready", 256'(JOB_READY), 256'(1));
        chk("reset_req_valid", 256'(REQ_VALID), 256'(0));
        chk("reset_busy", 256'(BUSY_TAGS), 256'(0));
        chk("reset_done", 256'(JOB_DONE), 256'(0));
        @(negedge CLK);
        #2;
        RST = 1'b0;

        // 1: single request
        submit(64'h1000, 32'd256, 1);
        wait_cnt(1);
        chk("t1_busy", 256'(BUSY_TAGS), 256'(1));
        chk("t1_size0", 256'(SIZE_TAGS[10:0]), 256'(64));
        force_comp(16'h0001);
        wait_done();
        chk("t1_word_count", 256'(WORD_COUNT), 256'(64));

        // 2: 4 KB crossing split
        submit(64'hF80, 32'd512, 2);
        wait_cnt(2);
        force_comp(16'h0003);
        wait_done();

        // 3: window of 2 stalls the third request until a tag is released
        CURRENT_WINDOW_SIZE = 64'd2;
        submit(64'h0, 32'd2048, 2);
        wait_cnt(2);
        repeat (10) tick();
        chk("t3_stalled_valid", 256'(REQ_VALID), 256'(0));
        chk("t3_pending", 256'(exp_q.size()), 256'(2));
        force_comp(16'h0001);
        wait_cnt(2);
        force_comp(16'h0002);
        wait_cnt(2);
        force_comp(16'h0003);
        wait_done();
        CURRENT_WINDOW_SIZE = 64'd0;

        // 4: back-pressure holds the request stable
        ready_mode = 2;
        submit(64'h1000, 32'd256, 1);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (REQ_VALID) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t4_valid_timeout", 256'(ok), 256'(1));
        a0 = REQ_ADDR;
        d0 = REQ_DWORDS;
        t0 = REQ_TAG;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t4_valid_held", 256'(REQ_VALID), 256'(1));
            chk("t4_addr_stable", 256'(REQ_ADDR), 256'(a0));
            chk("t4_dwords_stable", 256'(REQ_DWORDS), 256'(d0));
            chk("t4_tag_stable", 256'(REQ_TAG), 256'(t0));
            chk("t4_busy_unchanged", 256'(BUSY_TAGS), 256'(0));
        end
        ready_mode = 1;
        wait_cnt(1);
        chk("t4_busy_set", 256'(BUSY_TAGS), 256'(1));

        // 5: release of a non-busy tag
        force_comp(16'h0008);
        chk("t5_error", 256'(ERROR), 256'(1));
        chk("t5_busy", 256'(BUSY_TAGS), 256'(1));
        force_comp(16'h0001);
        wait_done();
        chk("t5_error_sticky", 256'(ERROR), 256'(1));

        // 6: asynchronous reset mid-job
        submit(64'h3000, 32'd4096, 0);
        wait_cnt(3);
        #1;
        RST = 1'b1;
        #1;
        chk("t6_busy", 256'(BUSY_TAGS), 256'(0));
        chk("t6_req_valid", 256'(REQ_VALID), 256'(0));
        chk("t6_error", 256'(ERROR), 256'(0));
        chk("t6_job_ready", 256'(JOB_READY), 256'(1));
        comp_force_req = 1'b0;
        @(negedge CLK);
        #2;
        RST = 1'b0;
        submit(64'h2000, 32'd1024, 2);
        wait_cnt(2);
        force_comp(16'h0003);
        wait_done();

        // zero-length job goes straight to done
        submit(64'h5000, 32'd3, 0);
        wait_done();

        // random jobs
        ready_mode = 0;
        comp_mode  = 1;
        for (int n = 0; n < 30; n++) begin
            logic [63:0] ra;
            ra = (64'($urandom_range(0, 7)) << 12) + 64'($urandom_range(0, 4095));
            if (n % 7 == 3) ra = {32'hFFFF_FFFF, 32'hFFFF_F000} + 64'($urandom_range(0, 4095));
            else if (n % 5 == 1) ra = ra + {$urandom, 32'd0};
            CURRENT_WINDOW_SIZE = 64'($urandom_range(0, 20));
            submit(ra, 32'($urandom_range(0, 3000)), 0);
            wait_done();
        end

        chk("requests_left", 256'(exp_q.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
